i2c_slave: RTL and testbench

- I2C target (slave) that answers the team's i2c master on the same two-wire bus.
- Decodes START, STOP and repeated START, matches a 7-bit address, and ACKs/NACKs.
- Bridges bus writes and reads onto a simple local register port: 8-bit register pointer with auto-increment, 8-bit data.
- Sits at the bus edge of sensor/peripheral models and on-chip register banks.

---
 rtl/i2c_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target with 7-bit address match, bridging bus writes/reads onto a local
// register port with an auto-incrementing 8-bit pointer.
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       open_drain,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oen,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       addressed,
  output logic       done
);

  localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, RX_PTR, ACK_PTR, RX_DATA, ACK_DATA, TX_DATA, RX_ACK, WAIT_STOP
  } state_e;

  logic [NS-1:0] scl_sync_q, sda_sync_q;
  logic          scl_h_q, sda_h_q;
  logic          scl_s, sda_s;
  logic          scl_rise, scl_fall, start_det, stop_det;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        sda_bit_q, sda_bit_d;
  logic        drive_q, drive_d;
  logic        ack_phase_q, ack_phase_d;
  logic        rw_q, rw_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_req_q, rd_req_d;
  logic        cap_q, cap_d;
  logic        addressed_q, addressed_d;
  logic        done_q, done_d;
  logic [7:0]  rx_byte;
  logic        drive;

  assign scl_s     = scl_sync_q[NS-1];
  assign sda_s     = sda_sync_q[NS-1];
  assign scl_rise  = scl_s & ~scl_h_q;
  assign scl_fall  = ~scl_s & scl_h_q;
  assign start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_bit_d   = sda_bit_q;
    drive_d     = drive_q;
    ack_phase_d = ack_phase_q;
    rw_d        = rw_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    addressed_d = addressed_q;
    wr_en_d     = 1'b0;
    done_d      = 1'b0;
    rd_pend_d   = 1'b0;
    rd_req_d    = rd_pend_q;
    cap_d       = rd_req_q;

    if (wr_en_q) reg_addr_d = reg_addr_q + 8'd1;
    // Read data lands in the shift register well before the SCL fall that sends its MSB.
    if (cap_q) shift_d = rd_data;

    if (start_det) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      sda_bit_d   = 1'b1;
      drive_d     = 1'b0;
      ack_phase_d = 1'b0;
      addressed_d = 1'b0;
      rd_req_d    = 1'b0;
      cap_d       = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE;
      sda_bit_d   = 1'b1;
      drive_d     = 1'b0;
      ack_phase_d = 1'b0;
      addressed_d = 1'b0;
      done_d      = addressed_q;
      rd_req_d    = 1'b0;
      cap_d       = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              state_d     = ACK_ADDR;
              rw_d        = rx_byte[0];
              ack_phase_d = 1'b0;
              rd_pend_d   = rx_byte[0];
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ACK_ADDR, ACK_PTR, ACK_DATA: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_bit_d   = 1'b0;
            drive_d     = 1'b1;
            ack_phase_d = 1'b1;
            if (state_q == ACK_ADDR) addressed_d = 1'b1;
          end else begin
            ack_phase_d = 1'b0;
            bit_cnt_d   = '0;
            if (state_q == ACK_ADDR && rw_q) begin
              sda_bit_d = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b1};
              bit_cnt_d = 4'd1;
              state_d   = TX_DATA;
            end else begin
              sda_bit_d = 1'b1;
              drive_d   = 1'b0;
              state_d   = (state_q == ACK_ADDR) ? RX_PTR : RX_DATA;
            end
          end
        end
        RX_PTR, RX_DATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d   = '0;
            ack_phase_d = 1'b0;
            if (state_q == RX_PTR) begin
              reg_addr_d = rx_byte;
              state_d    = ACK_PTR;
            end else begin
              wr_data_d = rx_byte;
              wr_en_d   = 1'b1;
              state_d   = ACK_DATA;
            end
          end
        end
        TX_DATA: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_bit_d = 1'b1;
            drive_d   = 1'b0;
            bit_cnt_d = '0;
            state_d   = RX_ACK;
          end else begin
            sda_bit_d = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b1};
            drive_d   = 1'b1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        RX_ACK: if (scl_rise) begin
          if (!sda_s) begin
            reg_addr_d = reg_addr_q + 8'd1;
            rd_pend_d  = 1'b1;
            bit_cnt_d  = '0;
            state_d    = TX_DATA;
          end else begin
            state_d = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_h_q     <= 1'b1;
      sda_h_q     <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sda_bit_q   <= 1'b1;
      drive_q     <= 1'b0;
      ack_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      reg_addr_q  <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_req_q    <= 1'b0;
      cap_q       <= 1'b0;
      addressed_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[NS-2:0], scl_in};
      sda_sync_q  <= {sda_sync_q[NS-2:0], sda_in};
      scl_h_q     <= scl_s;
      sda_h_q     <= sda_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_bit_q   <= sda_bit_d;
      drive_q     <= drive_d;
      ack_phase_q <= ack_phase_d;
      rw_q        <= rw_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_pend_q   <= rd_pend_d;
      rd_req_q    <= rd_req_d;
      cap_q       <= cap_d;
      addressed_q <= addressed_d;
      done_q      <= done_d;
    end
  end

  // Reset gates the pad drive directly so SDA is freed in the cycle reset is seen.
  assign drive     = drive_q & ~reset;
  assign sda_out   = open_drain ? 1'b0 : (drive ? sda_bit_q : 1'b1);
  assign sda_oen   = open_drain ? (drive ? sda_bit_q : 1'b1) : ~drive;
  assign reg_addr  = reg_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign rd_req    = rd_req_q;
  assign addressed = addressed_q;
  assign done      = done_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bus master model drives SCL/SDA on a wired-AND
// bus while a registered memory model answers the local read port.
module tb_i2c_slave;

  localparam time Q = 100ns;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       open_drain = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_out, sda_oen;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_en, rd_req, addressed, done;

  int unsigned checks = 0;
  int unsigned failures = 0;

  int unsigned wr_cnt = 0, rd_cnt = 0, done_cnt = 0, drv_cnt = 0;
  int unsigned viol_cnt = 0, pp_hi_cnt = 0, both_cnt = 0;
  logic [7:0]  wr_a [0:15];
  logic [7:0]  wr_d [0:15];
  logic [7:0]  rd_a [0:15];

  assign sda_bus = sda_m & (sda_oen ? 1'b1 : sda_out);

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .open_drain(open_drain),
    .scl_in(scl_m), .sda_in(sda_bus),
    .sda_out(sda_out), .sda_oen(sda_oen),
    .reg_addr(reg_addr), .wr_data(wr_data), .wr_en(wr_en),
    .rd_req(rd_req), .rd_data(rd_data),
    .addressed(addressed), .done(done)
  );

  always #5ns clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  always @(posedge clk) if (rd_req) rd_data <= mem_f(reg_addr);

  always @(negedge clk) begin
    if (wr_en) begin
      wr_a[wr_cnt % 16] <= reg_addr;
      wr_d[wr_cnt % 16] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_req) begin
      rd_a[rd_cnt % 16] <= reg_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (!sda_oen) drv_cnt <= drv_cnt + 1;
    if (wr_en && rd_req) both_cnt <= both_cnt + 1;
    if (open_drain && sda_out !== 1'b0) viol_cnt <= viol_cnt + 1;
    if (!open_drain && sda_oen && sda_out !== 1'b1) viol_cnt <= viol_cnt + 1;
    if (!open_drain && !sda_oen && sda_out) pp_hi_cnt <= pp_hi_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic bit_x(input logic b, output logic s);
    sda_m = b; #Q; scl_m = 1'b1; #Q; s = sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, ack);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(1'b1, v[i]);
    bit_x(nack, s);
  endtask

  task automatic read_seq(input string tag);
    logic ack;
    logic [7:0] v;
    i2c_start();
    wbyte(8'hA0, ack); check({tag, "_ack_a0"}, ack, 1'b0);
    wbyte(8'h10, ack); check({tag, "_ack_ptr"}, ack, 1'b0);
    i2c_start();
    wbyte(8'hA1, ack); check({tag, "_ack_a1"}, ack, 1'b0);
    rbyte(1'b0, v);    check({tag, "_byte0"}, v, 8'h3D);
    rbyte(1'b1, v);    check({tag, "_byte1"}, v, 8'h2D);
    i2c_stop();
  endtask

  initial begin
    logic ack;
    logic [7:0] v;
    int unsigned wr0, rd0, dn0, dv0, pp0;

    #2ns;
    repeat (4) @(posedge clk);
    #1ns;
    check("rst_sda_out_od", sda_out, 1'b0);
    check("rst_sda_oen", sda_oen, 1'b1);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_strobes", {wr_en, rd_req, addressed, done}, 4'b0000);
    open_drain = 1'b0; #1ns;
    check("rst_sda_out_pp", sda_out, 1'b1);
    open_drain = 1'b1;
    reset = 1'b0;
    #(4*Q);

    // Write two bytes from pointer 0x10
    wr0 = wr_cnt; dn0 = done_cnt;
    i2c_start();
    wbyte(8'hA0, ack); check("wr_ack_addr", ack, 1'b0);
    check("wr_addressed", addressed, 1'b1);
    wbyte(8'h10, ack); check("wr_ack_ptr", ack, 1'b0);
    wbyte(8'h5A, ack); check("wr_ack_d0", ack, 1'b0);
    wbyte(8'hC3, ack); check("wr_ack_d1", ack, 1'b0);
    i2c_stop();
    check("wr_count", wr_cnt - wr0, 2);
    check("wr0", {wr_a[wr0 % 16], wr_d[wr0 % 16]}, 16'h105A);
    check("wr1", {wr_a[(wr0 + 1) % 16], wr_d[(wr0 + 1) % 16]}, 16'h11C3);
    check("wr_ptr_after", reg_addr, 8'h12);
    check("wr_done", done_cnt - dn0, 1);
    check("wr_addressed_after", addressed, 1'b0);

    // Combined read across pointer wrap
    rd0 = rd_cnt; dn0 = done_cnt;
    i2c_start();
    wbyte(8'hA0, ack); check("rd_ack_a0", ack, 1'b0);
    wbyte(8'hFE, ack); check("rd_ack_ptr", ack, 1'b0);
    i2c_start();
    wbyte(8'hA1, ack); check("rd_ack_a1", ack, 1'b0);
    rbyte(1'b0, v); check("rd_byte_fe", v, 8'hD3);
    rbyte(1'b0, v); check("rd_byte_ff", v, 8'hC3);
    rbyte(1'b1, v); check("rd_byte_00", v, 8'h3C);
    i2c_stop();
    check("rd_count", rd_cnt - rd0, 3);
    check("rd_addrs", {rd_a[rd0 % 16], rd_a[(rd0 + 1) % 16], rd_a[(rd0 + 2) % 16]}, 24'hFEFF00);
    check("rd_ptr_after", reg_addr, 8'h00);
    check("rd_done", done_cnt - dn0, 1);

    // Foreign address: bus must stay untouched
    wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; dv0 = drv_cnt;
    i2c_start();
    wbyte(8'hA4, ack); check("na_ack_addr", ack, 1'b1);
    check("na_addressed", addressed, 1'b0);
    wbyte(8'h10, ack); check("na_ack_byte", ack, 1'b1);
    i2c_stop();
    check("na_drive", drv_cnt - dv0, 0);
    check("na_wr_rd", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
    check("na_done", done_cnt - dn0, 0);

    // STOP after four data bits
    wr0 = wr_cnt; dn0 = done_cnt;
    i2c_start();
    wbyte(8'hA0, ack); check("ms_ack_addr", ack, 1'b0);
    wbyte(8'h20, ack); check("ms_ack_ptr", ack, 1'b0);
    bit_x(1'b1, ack); bit_x(1'b0, ack); bit_x(1'b1, ack); bit_x(1'b0, ack);
    i2c_stop();
    check("ms_wr", wr_cnt - wr0, 0);
    check("ms_done", done_cnt - dn0, 1);
    check("ms_sda_oen", sda_oen, 1'b1);
    check("ms_addressed", addressed, 1'b0);
    check("ms_ptr", reg_addr, 8'h20);

    // Reset while sending a 0 bit (pointer 0x00 reads 0x3C, MSB 0)
    i2c_start();
    wbyte(8'hA0, ack); check("rt_ack_a0", ack, 1'b0);
    wbyte(8'h00, ack); check("rt_ack_ptr", ack, 1'b0);
    i2c_start();
    wbyte(8'hA1, ack); check("rt_ack_a1", ack, 1'b0);
    check("rt_driving_msb", sda_oen, 1'b0);
    reset = 1'b1;
    #1ns;
    check("rt_release_now", sda_oen, 1'b1);
    @(posedge clk); #1ns;
    check("rt_sda_oen", sda_oen, 1'b1);
    check("rt_sda_out", sda_out, 1'b0);
    check("rt_regs", {reg_addr, wr_data}, 16'h0000);
    check("rt_strobes", {wr_en, rd_req, addressed, done}, 4'b0000);
    @(posedge clk); #1ns;
    reset = 1'b0;
    #(2*Q);
    i2c_start();
    wbyte(8'hA1, ack); check("rt_ack_again", ack, 1'b0);
    rbyte(1'b1, v); check("rt_byte", v, 8'h3C);
    i2c_stop();

    // Same read in push-pull and open-drain modes
    pp0 = pp_hi_cnt;
    open_drain = 1'b0;
    #Q;
    read_seq("pp");
    check("pp_high_driven", (pp_hi_cnt - pp0) > 0, 1'b1);
    open_drain = 1'b1;
    #Q;
    read_seq("od");

    check("drive_rule_violations", viol_cnt, 0);
    check("wr_rd_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
